alu_stage: RTL and testbench

ALU_STAGE -- requirements
Module: alu_stage

---
 rtl/arm_pkg.sv | 48 ++++
 rtl/cond_check.sv | 43 ++++
 rtl/alu_stage.sv | 151 +++++++++++++++
 tb/tb_alu_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM data-processing opcode and condition-code constants,
// plus small opcode classification helpers used by the execute stage.
package arm_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'h0,
      OP_EOR = 4'h1,
      OP_SUB = 4'h2,
      OP_RSB = 4'h3,
      OP_ADD = 4'h4,
      OP_ADC = 4'h5,
      OP_SBC = 4'h6,
      OP_RSC = 4'h7,
      OP_TST = 4'h8,
      OP_TEQ = 4'h9,
      OP_CMP = 4'hA,
      OP_CMN = 4'hB,
      OP_ORR = 4'hC,
      OP_MOV = 4'hD,
      OP_BIC = 4'hE,
      OP_MVN = 4'hF
   } opcode_e;

   typedef enum logic [3:0] {
      CC_EQ = 4'h0,
      CC_NE = 4'h1,
      CC_CS = 4'h2,
      CC_CC = 4'h3,
      CC_MI = 4'h4,
      CC_PL = 4'h5,
      CC_VS = 4'h6,
      CC_VC = 4'h7,
      CC_HI = 4'h8,
      CC_LS = 4'h9,
      CC_GE = 4'hA,
      CC_LT = 4'hB,
      CC_GT = 4'hC,
      CC_LE = 4'hD,
      CC_AL = 4'hE,
      CC_NV = 4'hF
   } cond_e;

   // Compare/test ops set flags but never write the register file.
   function automatic logic is_test(opcode_e op);
      return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
   endfunction

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational ARM condition evaluator.
// Ports: cond (condition field), nzcv ({N,Z,C,V}), pass (condition met).
module cond_check
   import arm_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   assign w_n = nzcv[3];
   assign w_z = nzcv[2];
   assign w_c = nzcv[1];
   assign w_v = nzcv[0];

   always_comb begin
      pass = 1'b0;
      unique case (cond_e'(cond))
         CC_EQ: pass = w_z;
         CC_NE: pass = !w_z;
         CC_CS: pass = w_c;
         CC_CC: pass = !w_c;
         CC_MI: pass = w_n;
         CC_PL: pass = !w_n;
         CC_VS: pass = w_v;
         CC_VC: pass = !w_v;
         CC_HI: pass = w_c && !w_z;
         CC_LS: pass = !w_c || w_z;
         CC_GE: pass = (w_n == w_v);
         CC_LT: pass = (w_n != w_v);
         CC_GT: pass = !w_z && (w_n == w_v);
         CC_LE: pass = w_z || (w_n != w_v);
         CC_AL: pass = 1'b1;
         CC_NV: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_stage.sv
// alu_stage: one-cycle ARM data-processing execute stage with valid/ready
// handshake, condition check, flag register and register-file write request.
// Ports: clk/reset_n, upstream valid_in/ready_in + opcode, cond, s_bit, rd_in,
// op_a, op_b, shift_carry; downstream valid_out/ready_out + result, rd_out,
// wr_en, exec_out; nzcv is the architectural flag register {N,Z,C,V}.
module alu_stage
   import arm_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_in,
   output logic              ready_in,
   input  logic [3:0]        opcode,
   input  logic [3:0]        cond,
   input  logic              s_bit,
   input  logic [3:0]        rd_in,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              shift_carry,
   output logic              valid_out,
   input  logic              ready_out,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        rd_out,
   output logic              wr_en,
   output logic              exec_out,
   output logic [3:0]        nzcv
);

   logic              r_valid;
   logic [DATA_W-1:0] r_result;
   logic [3:0]        r_rd;
   logic              r_wr_en;
   logic              r_exec;
   logic [3:0]        r_nzcv;

   logic              w_accept;
   logic              w_exec;
   logic              w_test;
   logic              w_upd;
   opcode_e           w_op;
   logic              w_arith;
   logic [DATA_W-1:0] w_x;
   logic [DATA_W-1:0] w_y;
   logic              w_cin;
   logic [DATA_W-1:0] w_logic;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W-1:0] w_res;
   logic [3:0]        w_flags;

   assign ready_in = !r_valid || ready_out;
   assign w_accept = valid_in && ready_in;

   cond_check u_cond (
      .cond (cond),
      .nzcv (r_nzcv),
      .pass (w_exec)
   );

   // Subtractions are folded into one adder as x + ~y + cin, so the
   // adder carry-out is directly the ARM "not borrow" C flag.
   always_comb begin
      w_op    = opcode_e'(opcode);
      w_arith = 1'b0;
      w_x     = op_a;
      w_y     = op_b;
      w_cin   = 1'b0;
      w_logic = '0;
      unique case (w_op)
         OP_AND, OP_TST: w_logic = op_a & op_b;
         OP_EOR, OP_TEQ: w_logic = op_a ^ op_b;
         OP_ORR:         w_logic = op_a | op_b;
         OP_MOV:         w_logic = op_b;
         OP_BIC:         w_logic = op_a & ~op_b;
         OP_MVN:         w_logic = ~op_b;
         OP_SUB, OP_CMP: begin
            w_arith = 1'b1;
            w_y     = ~op_b;
            w_cin   = 1'b1;
         end
         OP_RSB: begin
            w_arith = 1'b1;
            w_x     = op_b;
            w_y     = ~op_a;
            w_cin   = 1'b1;
         end
         OP_ADD, OP_CMN: w_arith = 1'b1;
         OP_ADC: begin
            w_arith = 1'b1;
            w_cin   = r_nzcv[1];
         end
         OP_SBC: begin
            w_arith = 1'b1;
            w_y     = ~op_b;
            w_cin   = r_nzcv[1];
         end
         OP_RSC: begin
            w_arith = 1'b1;
            w_x     = op_b;
            w_y     = ~op_a;
            w_cin   = r_nzcv[1];
         end
      endcase
      w_sum = {1'b0, w_x} + {1'b0, w_y}
            + {{DATA_W{1'b0}}, w_cin};
      w_res = w_arith ? w_sum[DATA_W-1:0] : w_logic;
      w_flags[3] = w_res[DATA_W-1];
      w_flags[2] = (w_res == '0);
      w_flags[1] = w_arith ? w_sum[DATA_W] : shift_carry;
      w_flags[0] = w_arith
                 ? ((w_x[DATA_W-1] == w_y[DATA_W-1])
                    && (w_res[DATA_W-1] != w_x[DATA_W-1]))
                 : r_nzcv[0];
   end

   assign w_test = is_test(w_op);
   assign w_upd  = w_accept && w_exec && (s_bit || w_test);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_valid  <= 1'b0;
         r_result <= '0;
         r_rd     <= '0;
         r_wr_en  <= 1'b0;
         r_exec   <= 1'b0;
         r_nzcv   <= '0;
      end else begin
         if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_exec ? w_res : '0;
            r_rd     <= rd_in;
            r_wr_en  <= w_exec && !w_test;
            r_exec   <= w_exec;
         end else if (ready_out) begin
            r_valid  <= 1'b0;
         end
         if (w_upd) begin
            r_nzcv <= w_flags;
         end
      end
   end

   assign valid_out = r_valid;
   assign result    = r_result;
   assign rd_out    = r_rd;
   assign wr_en     = r_wr_en;
   assign exec_out  = r_exec;
   assign nzcv      = r_nzcv;

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed corner cases plus randomized traffic for alu_stage,
// checked against an arithmetic reference model of the ARM ALU rules.
module tb_alu_stage;

   localparam longint SMAX = 64'sh7FFFFFFF;
   localparam longint SMIN = -SMAX - 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid_in;
   logic        ready_in;
   logic [3:0]  opcode;
   logic [3:0]  cond;
   logic        s_bit;
   logic [3:0]  rd_in;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        shift_carry;
   logic        valid_out;
   logic        ready_out;
   logic [31:0] result;
   logic [3:0]  rd_out;
   logic        wr_en;
   logic        exec_out;
   logic [3:0]  nzcv;

   int n_vec = 0;
   int n_err = 0;

   logic        m_known = 1'b0;
   logic        m_valid;
   logic [31:0] m_res;
   logic [3:0]  m_rd;
   logic        m_wr;
   logic        m_exec;
   logic [3:0]  m_nzcv;

   always #5 clk = ~clk;

   alu_stage #(.DATA_W(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .valid_in    (valid_in),
      .ready_in    (ready_in),
      .opcode      (opcode),
      .cond        (cond),
      .s_bit       (s_bit),
      .rd_in       (rd_in),
      .op_a        (op_a),
      .op_b        (op_b),
      .shift_carry (shift_carry),
      .valid_out   (valid_out),
      .ready_out   (ready_out),
      .result      (result),
      .rd_out      (rd_out),
      .wr_en       (wr_en),
      .exec_out    (exec_out),
      .nzcv        (nzcv)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic cond_ok(input logic [3:0] c,
                                    input logic [3:0] f);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Arithmetic done on wide integers: unsigned value for carry/borrow,
   // signed value for overflow.
   task automatic ref_alu(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [3:0] f,
                          input logic shc,
                          output logic [31:0] r,
                          output logic [3:0] nf);
      longint ua, ub, sa, sb, u, s, ci;
      logic arith, sub;
      ua = longint'(a); ub = longint'(b);
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ci = longint'(f[1]);
      arith = 1'b1; sub = 1'b1; u = 0; s = 0; r = '0;
      case (op)
         4'h2, 4'hA: begin u = ua - ub; s = sa - sb; end
         4'h3: begin u = ub - ua; s = sb - sa; end
         4'h6: begin u = ua - ub - (1 - ci); s = sa - sb - (1 - ci); end
         4'h7: begin u = ub - ua - (1 - ci); s = sb - sa - (1 - ci); end
         4'h4, 4'hB: begin sub = 1'b0; u = ua + ub; s = sa + sb; end
         4'h5: begin sub = 1'b0; u = ua + ub + ci; s = sa + sb + ci; end
         default: begin
            arith = 1'b0;
            case (op)
               4'h0, 4'h8: r = a & b;
               4'h1, 4'h9: r = a ^ b;
               4'hC: r = a | b;
               4'hD: r = b;
               4'hE: r = a & ~b;
               default: r = ~b;
            endcase
         end
      endcase
      if (arith) begin
         r = u[31:0];
         nf[1] = sub ? (u >= 0) : (u > 64'sh0FFFFFFFF);
         nf[0] = (s > SMAX) || (s < SMIN);
      end else begin
         nf[1] = shc;
         nf[0] = f[0];
      end
      nf[3] = r[31];
      nf[2] = (r == 32'h0);
   endtask

   task automatic step();
      logic acc, pass, tst;
      logic [31:0] r;
      logic [3:0] nf;
      #1;
      if (m_known)
         check("ready_in", ready_in, !m_valid || ready_out);
      acc = valid_in && (!m_valid || ready_out);
      if (!reset_n) begin
         m_valid = 0; m_res = 0; m_rd = 0;
         m_wr = 0; m_exec = 0; m_nzcv = 0;
      end else if (acc) begin
         ref_alu(opcode, op_a, op_b, m_nzcv, shift_carry, r, nf);
         pass = cond_ok(cond, m_nzcv);
         tst = (opcode >= 4'h8) && (opcode <= 4'hB);
         m_valid = 1;
         m_rd = rd_in;
         m_exec = pass;
         m_wr = pass && !tst;
         m_res = pass ? r : 32'h0;
         if (pass && (s_bit || tst)) m_nzcv = nf;
      end else if (ready_out) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
      if (!reset_n) m_known = 1'b1;
      check("valid_out", valid_out, m_valid);
      check("nzcv", nzcv, m_nzcv);
      if (m_valid) begin
         check("result", result, m_res);
         check("rd_out", rd_out, m_rd);
         check("wr_en", wr_en, m_wr);
         check("exec_out", exec_out, m_exec);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] c,
                        input logic s, input logic [3:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic shc);
      valid_in = 1; opcode = op; cond = c; s_bit = s;
      rd_in = rd; op_a = a; op_b = b; shift_carry = shc;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h7FFFFFFF;
         2: return 32'h80000000;
         3: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset_n = 0; valid_in = 1; ready_out = 1;
      opcode = 0; cond = 4'hE; s_bit = 0; rd_in = 0;
      op_a = 0; op_b = 0; shift_carry = 0;
      step();
      valid_in = 0;
      step();
      reset_n = 1;
      #1;
      check("rst_valid", valid_out, 1'b0);
      check("rst_nzcv", nzcv, 4'h0);
      check("rst_result", result, 32'h0);
      check("rst_rd", rd_out, 4'h0);
      check("rst_wr", wr_en, 1'b0);
      check("rst_exec", exec_out, 1'b0);
      check("rst_ready", ready_in, 1'b1);

      drive(4'h4, 4'hE, 1, 4'h1, 32'h7FFFFFFF, 32'h1, 0);
      step();
      check("adds_res", result, 32'h80000000);
      check("adds_nzcv", nzcv, 4'b1001);

      drive(4'h0, 4'hE, 1, 4'h2, 32'hF0, 32'h0F, 1);
      step();
      check("ands_res", result, 32'h0);
      check("ands_nzcv", nzcv, 4'b0111);

      drive(4'h2, 4'hE, 1, 4'h3, 32'h5, 32'h5, 0);
      step();
      check("subs_nzcv", nzcv, 4'b0110);
      drive(4'hD, 4'h0, 0, 4'h4, 32'h0, 32'h12, 0);
      step();
      check("moveq_exec", exec_out, 1'b1);
      check("moveq_wr", wr_en, 1'b1);
      check("moveq_res", result, 32'h12);

      drive(4'hA, 4'hE, 0, 4'h5, 32'h3, 32'h7, 0);
      step();
      check("cmp_wr", wr_en, 1'b0);
      check("cmp_nzcv", nzcv, 4'b1000);

      drive(4'h4, 4'h0, 1, 4'h6, 32'h1, 32'h1, 0);
      step();
      check("fail_exec", exec_out, 1'b0);
      check("fail_res", result, 32'h0);
      check("fail_nzcv", nzcv, 4'b1000);

      drive(4'hC, 4'hE, 0, 4'h7, 32'hA0, 32'h05, 0);
      step();
      ready_out = 0;
      drive(4'h4, 4'hE, 1, 4'h8, 32'hFFFFFFFF, 32'h1, 0);
      repeat (3) begin
         step();
         check("hold_ready", ready_in, 1'b0);
         check("hold_res", result, 32'hA5);
         check("hold_rd", rd_out, 4'h7);
         check("hold_nzcv", nzcv, 4'b1000);
      end
      ready_out = 1;
      step();
      check("rel_res", result, 32'h0);
      check("rel_nzcv", nzcv, 4'b0110);

      reset_n = 0;
      step();
      check("rst2_valid", valid_out, 1'b0);
      check("rst2_nzcv", nzcv, 4'h0);
      reset_n = 1;

      for (int i = 0; i < 600; i++) begin
         drive(4'($urandom), 4'($urandom_range(0, 15)),
               1'($urandom), 4'($urandom), pick(), pick(),
               1'($urandom));
         if ($urandom_range(0, 3) == 0) cond = 4'hE;
         valid_in = ($urandom_range(0, 4) != 0);
         ready_out = ($urandom_range(0, 4) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
